inst_fetch_queue: RTL and testbench

Instruction fetch front-end between the core's SRAM-like instruction bus (inst_req/inst_addr_ok/inst_data_ok) and the dual IF/ID issue pair. It keeps up to MAX_OUT requests in flight and buffers returned words with their PCs in an in-order queue. Each cycle it presents up to two consecutive instructions to the dual decoders. On a branch or jump redirect it flushes the queue and silently drops responses that are still in flight.

---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/inst_fetch_queue_if.sv | 19 +
 rtl/fetch_queue_ram.sv | 27 ++
 rtl/inst_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [2:0]  KSEG1    = 3'b101;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  // kseg1 is the only uncached segment seen by instruction fetch.
  function automatic logic is_cacheable(input logic [31:0] addr);
    return addr[31:29] != KSEG1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// SRAM-like instruction bus between the fetch queue (master) and memory (slave).
interface inst_fetch_queue_if;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  modport master (
    output inst_req, inst_cache, inst_addr,
    input  inst_rdata, inst_addr_ok, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_cache, inst_addr,
    output inst_rdata, inst_addr_ok, inst_data_ok
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// Queue storage: one synchronous write port, two asynchronous read ports.
module fetch_queue_ram
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  fetch_entry_t               i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr_1,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr_2,
  output fetch_entry_t               o_rdata_1,
  output fetch_entry_t               o_rdata_2
);

  fetch_entry_t r_mem [DEPTH];

  // Write the entry at the queue tail.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_1 = r_mem[i_raddr_1];
  assign o_rdata_2 = r_mem[i_raddr_2];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues bus requests, queues returned words
// with their PCs and presents the two oldest to the dual decoders.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = mips_fetch_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  inst_fetch_queue_if.master        bus,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  input  logic [1:0]                pop_cnt,
  output logic                      out_valid_1,
  output logic                      out_valid_2,
  output logic [31:0]               out_inst_1,
  output logic [31:0]               out_inst_2,
  output logic [31:0]               out_pc_1,
  output logic [31:0]               out_pc_2,
  output logic                      out_adel_1,
  output logic                      out_adel_2,
  output logic [$clog2(DEPTH):0]    count
);
  import mips_fetch_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [PW-1:0] PEND_LAST = PW'(MAX_OUT - 1);

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic          r_halted;
  logic [31:0]   r_pend [MAX_OUT];
  logic [PW-1:0] r_pend_rd;
  logic [PW-1:0] r_pend_wr;

  logic [CW:0]   w_occ;
  logic          w_aligned;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_resp_keep;
  logic          w_adel_push;
  logic          w_push;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_ent_1;
  fetch_entry_t  w_ent_2;

  // Request gating, response classification and queue push/pop amounts.
  always_comb begin
    w_occ       = {1'b0, r_count} + {1'b0, r_outst};
    w_aligned   = (r_fetch_pc[1:0] == 2'b00);
    // Reserving a slot per outstanding request means a response always fits.
    w_req       = !reset && !redirect && !r_halted && w_aligned &&
                  (r_outst < MAX_OUT_C) && (w_occ < DEPTH_OCC);
    w_accept    = w_req && bus.inst_addr_ok;
    w_resp      = bus.inst_data_ok && (r_outst != '0);
    w_resp_keep = w_resp && (r_discard == '0) && !redirect;
    w_adel_push = !redirect && !r_halted && !w_aligned &&
                  (r_outst == '0) && (r_discard == '0) && (r_count < DEPTH_C);
    w_push      = w_resp_keep || w_adel_push;
    w_pop_req   = (pop_cnt == 2'd0) ? CW'(0) : (pop_cnt == 2'd1) ? CW'(1) : CW'(2);
    w_pop       = (w_pop_req > r_count) ? r_count : w_pop_req;
    w_wdata     = '0;
    if (w_adel_push) begin
      w_wdata.pc   = r_fetch_pc;
      w_wdata.adel = 1'b1;
    end else begin
      w_wdata.pc   = r_pend[r_pend_rd];
      w_wdata.inst = bus.inst_rdata;
    end
  end

  // Pending-PC FIFO: one entry per accepted request, consumed by each response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_rd <= '0;
      r_pend_wr <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) r_pend[i] <= '0;
    end else begin
      if (w_resp) r_pend_rd <= (r_pend_rd == PEND_LAST) ? '0 : r_pend_rd + 1'b1;
      if (w_accept) begin
        r_pend[r_pend_wr] <= r_fetch_pc;
        r_pend_wr         <= (r_pend_wr == PEND_LAST) ? '0 : r_pend_wr + 1'b1;
      end
    end
  end

  // Fetch PC, queue pointers, in-flight bookkeeping; redirect overrides push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_outst <= r_outst + CW'(w_accept) - CW'(w_resp);
      if (redirect) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= redirect_pc;
        r_halted   <= 1'b0;
        // Everything still in flight after this cycle belongs to the old path.
        r_discard  <= r_outst - CW'(w_resp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_adel_push) r_halted <= 1'b1;
        r_head  <= r_head + AW'(w_pop);
        r_count <= r_count + CW'(w_push) - w_pop;
      end
    end
  end

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_we      (w_push),
    .i_waddr   (r_tail),
    .i_wdata   (w_wdata),
    .i_raddr_1 (r_head),
    .i_raddr_2 (r_head + 1'b1),
    .o_rdata_1 (w_ent_1),
    .o_rdata_2 (w_ent_2)
  );

  assign bus.inst_req   = w_req;
  assign bus.inst_addr  = r_fetch_pc;
  assign bus.inst_cache = is_cacheable(r_fetch_pc);

  // Issue slots; empty slots and the reset cycle drive all fields to zero.
  always_comb begin
    out_valid_1 = !reset && (r_count >= CW'(1));
    out_valid_2 = !reset && (r_count >= CW'(2));
    out_inst_1  = out_valid_1 ? w_ent_1.inst : '0;
    out_pc_1    = out_valid_1 ? w_ent_1.pc   : '0;
    out_adel_1  = out_valid_1 ? w_ent_1.adel : 1'b0;
    out_inst_2  = out_valid_2 ? w_ent_2.inst : '0;
    out_pc_2    = out_valid_2 ? w_ent_2.pc   : '0;
    out_adel_2  = out_valid_2 ? w_ent_2.adel : 1'b0;
  end

  assign count = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a one-cycle-latency memory model.
module tb_inst_fetch_queue;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  pop_cnt;
  logic        out_valid_1, out_valid_2;
  logic [31:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
  logic        out_adel_1, out_adel_2;
  logic [3:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mq [$];
  logic        hold_data;

  always #5 clk = ~clk;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(.DEPTH(8), .MAX_OUT(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pop_cnt     (pop_cnt),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_inst_1  (out_inst_1),
    .out_inst_2  (out_inst_2),
    .out_pc_1    (out_pc_1),
    .out_pc_2    (out_pc_2),
    .out_adel_1  (out_adel_1),
    .out_adel_2  (out_adel_2),
    .count       (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Memory returns ~addr one cycle after acceptance unless hold_data is set.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    bus.inst_addr_ok = 1'b1;
    bus.inst_data_ok = !hold_data && (mq.size() > 0);
    bus.inst_rdata   = bus.inst_data_ok ? ~mq[0] : 32'h0;
    #1;
    assert (!(bus.inst_data_ok && mq.size() == 0)) else $error("data_ok with nothing outstanding");
    acc = bus.inst_req && bus.inst_addr_ok;
    a   = bus.inst_addr;
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (bus.inst_data_ok) void'(mq.pop_front());
      if (acc) mq.push_back(a);
    end
    #1;
  endtask

  logic [31:0] exp_pc  [7] = '{32'hBFC0_0008, 32'hBFC0_0010, 32'hBFC0_0018, 32'hBFC0_0020,
                               32'hBFC0_0028, 32'hBFC0_002C, 32'hBFC0_0030};
  logic [3:0]  exp_cnt [7] = '{4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1};

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; pop_cnt = 2'd0; hold_data = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_req", bus.inst_req, 0);
    check("rst_valid1", out_valid_1, 0);
    check("rst_count", count, 0);
    reset = 1'b0;
    settle();
    check("first_req", bus.inst_req, 1);
    check("first_addr", bus.inst_addr, 32'hBFC0_0000);
    check("first_cache", bus.inst_cache, 0);

    // Fill with no pops
    for (int i = 0; i < 8; i++) tick();
    check("fill_cnt7", count, 7);
    check("fill_req_blocked", bus.inst_req, 0);
    tick();
    check("fill_cnt8", count, 8);
    check("fill_valid2", out_valid_2, 1);
    check("fill_pc1", out_pc_1, 32'hBFC0_0000);
    check("fill_pc2", out_pc_2, 32'hBFC0_0004);
    check("fill_inst1", out_inst_1, 32'h403F_FFFF);
    check("fill_inst2", out_inst_2, 32'h403F_FFFB);
    check("fill_adel1", out_adel_1, 0);

    // Streaming pops (first pop_cnt=3 behaves as 2)
    for (int i = 0; i < 7; i++) begin
      pop_cnt = (i == 0) ? 2'd3 : 2'd2;
      tick();
      check($sformatf("stream_pc_%0d", i), out_pc_1, exp_pc[i]);
      check($sformatf("stream_cnt_%0d", i), count, exp_cnt[i]);
    end

    // Redirect with three requests in flight
    pop_cnt = 2'd0; hold_data = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h8000_1000;
    settle();
    check("redir_req_low", bus.inst_req, 0);
    tick();
    check("redir_cnt0", count, 0);
    check("redir_valid1", out_valid_1, 0);
    redirect = 1'b0; hold_data = 1'b0;
    settle();
    check("redir_addr", bus.inst_addr, 32'h8000_1000);
    check("redir_cache", bus.inst_cache, 1);
    check("redir_req", bus.inst_req, 1);
    tick(); tick(); tick();
    check("discard3_cnt", count, 0);
    tick();
    check("new_path_cnt", count, 1);
    check("new_path_pc", out_pc_1, 32'h8000_1000);
    check("new_path_inst", out_inst_1, 32'h7FFF_EFFF);

    // Redirect coinciding with a kept-path data_ok
    redirect = 1'b1; redirect_pc = 32'h8000_2000;
    tick();
    check("redir2_cnt", count, 0);
    redirect = 1'b0;
    tick(); tick();
    check("discard2_cnt", count, 0);
    tick();
    check("redir2_cnt1", count, 1);
    check("redir2_pc", out_pc_1, 32'h8000_2000);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h8000_0002;
    tick();
    redirect = 1'b0;
    settle();
    check("adel_no_req", bus.inst_req, 0);
    tick();
    check("adel_wait_cnt", count, 0);
    tick();
    check("adel_cnt", count, 1);
    check("adel_valid", out_valid_1, 1);
    check("adel_pc", out_pc_1, 32'h8000_0002);
    check("adel_inst", out_inst_1, 0);
    check("adel_flag", out_adel_1, 1);
    check("adel_req", bus.inst_req, 0);
    tick();
    check("halt_cnt", count, 1);
    pop_cnt = 2'd3;
    tick();
    check("pop_clamp_cnt", count, 0);
    pop_cnt = 2'd0;
    tick();
    check("halt_no_repush", count, 0);
    check("halt_no_req", bus.inst_req, 0);

    // Reset mid-operation with count=5, outstanding=2
    redirect = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    redirect = 1'b0;
    settle();
    check("unhalt_req", bus.inst_req, 1);
    check("unhalt_addr", bus.inst_addr, 32'h8000_0000);
    for (int i = 0; i < 6; i++) tick();
    hold_data = 1'b1;
    tick();
    check("pre_rst_cnt", count, 5);
    check("pre_rst_pc", out_pc_1, 32'h8000_0000);
    reset = 1'b1;
    tick();
    check("mid_rst_cnt", count, 0);
    check("mid_rst_req", bus.inst_req, 0);
    check("mid_rst_v1", out_valid_1, 0);
    check("mid_rst_v2", out_valid_2, 0);
    reset = 1'b0; hold_data = 1'b0;
    settle();
    check("post_rst_req", bus.inst_req, 1);
    check("post_rst_addr", bus.inst_addr, 32'hBFC0_0000);
    tick(); tick();
    check("post_rst_pc", out_pc_1, 32'hBFC0_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
